alu_share_arbiter: RTL and testbench

- Shares the single combinational 32-bit ALU between two requesters: r0 (execute stage) and r1 (branch/compare unit).
- Each requester uses a valid/ready request channel and a registered valid/ready response channel.
- Arbitration is round-robin; one ALU operation issues per cycle; latency is one cycle.
- Sits between the requesters and the ALU instance, and drives the ALU's A, B, select, carry-in and sign inputs.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_rsp_slot.sv | 22 ++
 rtl/alu_share_arbiter.sv | 75 +++++++
 tb/tb_alu_share_arbiter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, default widths and request/response bundles
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_PASA = 4'hB;
  localparam logic [3:0] ALU_PASB = 4'hC;
  localparam logic [3:0] ALU_NOTA = 4'hD;
  localparam logic [3:0] ALU_NE   = 4'hE;
  localparam logic [3:0] ALU_EQ   = 4'hF;
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
    logic              cin;
    logic              sign;
  } alu_req_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;
  } alu_rsp_t;
endpackage

// File: rtl/alu_rsp_slot.sv
// alu_rsp_slot: one-entry registered response holder; a load wins over a drain
module alu_rsp_slot #(
  parameter int W = $bits(alu_pkg::alu_rsp_t)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q
);
  import alu_pkg::*;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) valid <= 1'b0;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEL_W  = alu_pkg::SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [SEL_W-1:0]  r0_sel,
  input  logic              r0_cin,
  input  logic              r0_sign,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_result,
  output logic              r0_zero,
  output logic              r0_ovf,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [SEL_W-1:0]  r1_sel,
  input  logic              r1_cin,
  input  logic              r1_sign,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_result,
  output logic              r1_zero,
  output logic              r1_ovf,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic              alu_cin,
  output logic              alu_sign,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  output logic              busy
);
  import alu_pkg::*;
  logic last, e0, e1, g0, g1;
  logic [DATA_W+1:0] d, q0, q1;
  // a full slot is still eligible when it drains this cycle
  assign e0 = r0_req_valid & (~r0_rsp_valid | r0_rsp_ready);
  assign e1 = r1_req_valid & (~r1_rsp_valid | r1_rsp_ready);
  assign g0 = rst_n & e0 & (~e1 | last);
  assign g1 = rst_n & e1 & (~e0 | ~last);
  assign r0_req_ready = g0;
  assign r1_req_ready = g1;
  always_comb begin
    alu_a    = g0 ? r0_a    : g1 ? r1_a    : '0;
    alu_b    = g0 ? r0_b    : g1 ? r1_b    : '0;
    alu_sel  = g0 ? r0_sel  : g1 ? r1_sel  : SEL_W'(ALU_ADD);
    alu_cin  = g0 ? r0_cin  : g1 & r1_cin;
    alu_sign = g0 ? r0_sign : g1 & r1_sign;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= 1'b1;
    else if (g0) last <= 1'b0;
    else if (g1) last <= 1'b1;
  assign d = {alu_out, alu_zero, alu_ovf};
  alu_rsp_slot #(.W(DATA_W + 2)) u_slot0 (
    .clk(clk), .rst_n(rst_n), .load(g0), .d(d),
    .ready(r0_rsp_ready), .valid(r0_rsp_valid), .q(q0)
  );
  alu_rsp_slot #(.W(DATA_W + 2)) u_slot1 (
    .clk(clk), .rst_n(rst_n), .load(g1), .d(d),
    .ready(r1_rsp_ready), .valid(r1_rsp_valid), .q(q1)
  );
  assign {r0_result, r0_zero, r0_ovf} = q0;
  assign {r1_result, r1_zero, r1_ovf} = q1;
  assign busy = r0_rsp_valid | r1_rsp_valid | r0_req_valid | r1_req_valid;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vectors with a queue scoreboard and an ALU model
module tb_alu_share_arbiter;
  logic clk = 0, rst_n = 0;
  logic r0_req_valid = 0, r1_req_valid = 0, r0_req_ready, r1_req_ready;
  logic [31:0] r0_a = 0, r0_b = 0, r1_a = 0, r1_b = 0;
  logic [3:0] r0_sel = 0, r1_sel = 0;
  logic r0_cin = 0, r0_sign = 0, r1_cin = 0, r1_sign = 0;
  logic r0_rsp_valid, r1_rsp_valid, r0_rsp_ready = 1, r1_rsp_ready = 1;
  logic [31:0] r0_result, r1_result;
  logic r0_zero, r0_ovf, r1_zero, r1_ovf;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel;
  logic alu_cin, alu_sign, alu_zero, alu_ovf, busy;
  logic [32:0] s, dd;
  logic [33:0] x0, x1;
  logic [33:0] q0[$], q1[$];
  int tests = 0, fails = 0;

  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_a(r0_a), .r0_b(r0_b),
    .r0_sel(r0_sel), .r0_cin(r0_cin), .r0_sign(r0_sign), .r0_rsp_valid(r0_rsp_valid),
    .r0_rsp_ready(r0_rsp_ready), .r0_result(r0_result), .r0_zero(r0_zero), .r0_ovf(r0_ovf),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_a(r1_a), .r1_b(r1_b),
    .r1_sel(r1_sel), .r1_cin(r1_cin), .r1_sign(r1_sign), .r1_rsp_valid(r1_rsp_valid),
    .r1_rsp_ready(r1_rsp_ready), .r1_result(r1_result), .r1_zero(r1_zero), .r1_ovf(r1_ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_cin(alu_cin), .alu_sign(alu_sign),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    s = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
    dd = {1'b0, alu_a} - {1'b0, alu_b};
    alu_out = 32'd0;
    alu_ovf = 1'b0;
    case (alu_sel)
      4'h0: begin
        alu_out = s[31:0];
        alu_ovf = alu_sign ? (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]) : s[32];
      end
      4'h1: begin
        alu_out = dd[31:0];
        alu_ovf = alu_sign ? (alu_a[31] != alu_b[31]) && (dd[31] != alu_a[31]) : dd[32];
      end
      4'hF: alu_out = {31'd0, alu_a == alu_b};
      default: alu_out = alu_a & alu_b;
    endcase
    alu_zero = alu_out == 32'd0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // one cycle: check grants at the falling edge, log expectations, advance past the rising edge
  task automatic step(input logic g0, input logic g1);
    @(negedge clk);
    check("r0_req_ready", 64'(r0_req_ready), 64'(g0));
    check("r1_req_ready", 64'(r1_req_ready), 64'(g1));
    if (!g0 && !g1)
      check("idle_alu_drive", 64'({alu_a, alu_b} | 64'({alu_sel, alu_cin, alu_sign})), 64'd0);
    if (r0_req_ready) q0.push_back(x0);
    if (r1_req_ready) q1.push_back(x1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) if (rst_n) begin
    if (r0_rsp_valid && r0_rsp_ready) begin
      if (q0.size() == 0) check("r0_unexpected_rsp", 64'({r0_result, r0_zero, r0_ovf}), 64'd0 - 1);
      else check("r0_rsp", 64'({r0_result, r0_zero, r0_ovf}), 64'(q0.pop_front()));
    end
    if (r1_rsp_valid && r1_rsp_ready) begin
      if (q1.size() == 0) check("r1_unexpected_rsp", 64'({r1_result, r1_zero, r1_ovf}), 64'd0 - 1);
      else check("r1_rsp", 64'({r1_result, r1_zero, r1_ovf}), 64'(q1.pop_front()));
    end
  end

  initial begin
    r0_req_valid = 1; r1_req_valid = 1;
    #3;
    check("reset_ready", 64'({r0_req_ready, r1_req_ready}), 64'd0);
    check("reset_rsp_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 64'd0);
    check("reset_r0", 64'({r0_result, r0_zero, r0_ovf}), 64'd0);
    check("reset_r1", 64'({r1_result, r1_zero, r1_ovf}), 64'd0);
    r0_req_valid = 0; r1_req_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    check("busy_idle", 64'(busy), 64'd0);
    // alternation from reset: r0 add 1+2, r1 sub 9-9
    r0_req_valid = 1; r0_a = 1; r0_b = 2; r0_sel = 0; x0 = {32'd3, 1'b0, 1'b0};
    r1_req_valid = 1; r1_a = 9; r1_b = 9; r1_sel = 1; x1 = {32'd0, 1'b1, 1'b0};
    step(1, 0); step(0, 1); step(1, 0); step(0, 1);
    check("busy_active", 64'(busy), 64'd1);
    // r0 alone: 5+7
    r1_req_valid = 0;
    r0_a = 5; r0_b = 7; x0 = {32'd12, 1'b0, 1'b0};
    step(1, 0);
    check("r0_latency_valid", 64'(r0_rsp_valid), 64'd1);
    r0_req_valid = 0;
    step(0, 0);
    // r0 stalls its response; r1 keeps the ALU every cycle
    r0_req_valid = 1; r0_a = 10; r0_b = 20; x0 = {32'd30, 1'b0, 1'b0};
    r1_req_valid = 1; r1_a = 3; r1_b = 4; r1_sel = 0; x1 = {32'd7, 1'b0, 1'b0};
    step(0, 1);
    r0_rsp_ready = 0;
    step(1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      check("r0_stall_hold", 64'({r0_rsp_valid, r0_result}), {31'd0, 1'b1, 32'd30});
    end
    r0_req_valid = 0; r1_req_valid = 0; r0_rsp_ready = 1;
    step(0, 0);
    step(0, 0);
    // back-to-back drain+load: 1+1 then 2+2
    r0_req_valid = 1; r0_a = 1; r0_b = 1; x0 = {32'd2, 1'b0, 1'b0};
    step(1, 0);
    r0_a = 2; r0_b = 2; x0 = {32'd4, 1'b0, 1'b0};
    step(1, 0);
    check("b2b_valid_held", 64'({r0_rsp_valid, r0_result}), {31'd0, 1'b1, 32'd4});
    r0_req_valid = 0;
    step(0, 0);
    check("drain_clears", 64'(r0_rsp_valid), 64'd0);
    // signed overflow on r1
    r1_req_valid = 1; r1_a = 32'h7FFF_FFFF; r1_b = 1; r1_sel = 0; r1_sign = 1;
    x1 = {32'h8000_0000, 1'b0, 1'b1};
    step(0, 1);
    r1_req_valid = 0; r1_sign = 0;
    step(0, 0);
    // asynchronous reset right after a capture
    r1_req_valid = 1; r1_a = 5; r1_b = 5; r1_sel = 1; x1 = {32'd0, 1'b1, 1'b0};
    step(0, 1);
    r1_req_valid = 0;
    #1 rst_n = 0;
    #1;
    check("async_reset_valid", 64'({r0_rsp_valid, r1_rsp_valid}), 64'd0);
    q0.delete(); q1.delete();
    #1 rst_n = 1;
    r0_req_valid = 1; r0_a = 4; r0_b = 4; r0_sel = 4'hF; x0 = {32'd1, 1'b0, 1'b0};
    r1_req_valid = 1; r1_a = 6; r1_b = 2; r1_sel = 1; x1 = {32'd4, 1'b0, 1'b0};
    step(1, 0); step(0, 1);
    r0_req_valid = 0; r1_req_valid = 0;
    step(0, 0); step(0, 0);
    check("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
